// File: rtl/inst_parser.sv
// rtl/inst_parser.sv - character stream word assembler and ATM command matcher
// Letters build a right-aligned window; a blank delimiter triggers a table match and a one-cycle strobe.
module inst_parser #(
   parameter int MAX_CHARS = 8,
   parameter int CHAR_W    = 5
) (
   input  logic                        sec_clock,
   input  logic                        reset,
   input  logic [CHAR_W-1:0]           char_in,
   input  logic                        char_valid,
   output logic                        char_ready,
   output logic                        cmd_valid,
   output logic [2:0]                  cmd_code,
   output logic                        cmd_error,
   output logic [3:0]                  word_len,
   output logic [MAX_CHARS*CHAR_W-1:0] window
);

   localparam int WIN_W = MAX_CHARS * CHAR_W;

   localparam logic [WIN_W-1:0] K_BALANCE  = WIN_W'({5'd2, 5'd1, 5'd12, 5'd1, 5'd14, 5'd3, 5'd5});
   localparam logic [WIN_W-1:0] K_DEPOSIT  = WIN_W'({5'd4, 5'd5, 5'd16, 5'd15, 5'd19, 5'd9, 5'd20});
   localparam logic [WIN_W-1:0] K_WITHDRAW = WIN_W'({5'd23, 5'd9, 5'd20, 5'd8, 5'd4, 5'd18, 5'd1, 5'd23});
   localparam logic [WIN_W-1:0] K_EXIT     = WIN_W'({5'd5, 5'd24, 5'd9, 5'd20});

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_DISCARD = 3'd2,
      S_MATCH   = 3'd3,
      S_EMIT    = 3'd4
   } state_t;

   state_t             r_state;
   logic [WIN_W-1:0]   r_window;
   logic [3:0]         r_len;
   logic [2:0]         r_code;
   logic               r_valid;
   logic               r_error;

   state_t             w_next_state;
   logic [WIN_W-1:0]   w_next_window;
   logic [3:0]         w_next_len;
   logic [2:0]         w_next_code;
   logic               w_next_valid;
   logic               w_next_error;
   logic               w_ready;
   logic               w_accept;
   logic               w_is_blank;
   logic               w_is_letter;
   logic [2:0]         w_match_code;

   assign w_ready     = (r_state == S_IDLE) || (r_state == S_COLLECT) || (r_state == S_DISCARD);
   assign w_accept    = char_valid && w_ready;
   assign w_is_blank  = (char_in == '0);
   assign w_is_letter = (char_in != '0) && (char_in <= CHAR_W'(26));

   // Length is part of the key so a prefix of a longer command never hits.
   assign w_match_code = ((r_len == 4'd7) && (r_window == K_BALANCE))  ? 3'd1 :
                         ((r_len == 4'd7) && (r_window == K_DEPOSIT))  ? 3'd2 :
                         ((r_len == 4'd8) && (r_window == K_WITHDRAW)) ? 3'd3 :
                         ((r_len == 4'd4) && (r_window == K_EXIT))     ? 3'd4 : 3'd0;

   always_comb begin
      w_next_state  = r_state;
      w_next_window = r_window;
      w_next_len    = r_len;
      w_next_code   = r_code;
      w_next_valid  = 1'b0;
      w_next_error  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept && !w_is_blank) begin
               if (w_is_letter) begin
                  w_next_window = WIN_W'(char_in);
                  w_next_len    = 4'd1;
                  w_next_state  = S_COLLECT;
               end else begin
                  w_next_state  = S_DISCARD;
               end
            end
         end
         S_COLLECT: begin
            if (w_accept) begin
               if (w_is_blank) begin
                  w_next_state = S_MATCH;
               end else if (w_is_letter && (r_len < 4'(MAX_CHARS))) begin
                  w_next_window = {r_window[WIN_W-CHAR_W-1:0], char_in};
                  w_next_len    = r_len + 4'd1;
               end else begin
                  w_next_state = S_DISCARD;
               end
            end
         end
         S_DISCARD: begin
            if (w_accept && w_is_blank) begin
               w_next_error  = 1'b1;
               w_next_window = '0;
               w_next_len    = 4'd0;
               w_next_state  = S_IDLE;
            end
         end
         S_MATCH: begin
            // Result lands in the output registers so it is visible during EMIT.
            w_next_code  = w_match_code;
            w_next_valid = (w_match_code != 3'd0);
            w_next_error = (w_match_code == 3'd0);
            w_next_state = S_EMIT;
         end
         S_EMIT: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sec_clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_window <= '0;
         r_len    <= 4'd0;
         r_code   <= 3'd0;
         r_valid  <= 1'b0;
         r_error  <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_window <= w_next_window;
         r_len    <= w_next_len;
         r_code   <= w_next_code;
         r_valid  <= w_next_valid;
         r_error  <= w_next_error;
      end
   end

   assign char_ready = w_ready;
   assign cmd_valid  = r_valid;
   assign cmd_error  = r_error;
   assign cmd_code   = r_code;
   assign word_len   = r_len;
   assign window     = r_window;

endmodule
